// File: rtl/count_sched.sv
// -----------------------------------------------------------------------------
// count_sched
//
// Round-robin scheduler that time-shares one WIDTH-bit up-counter among N_REQ
// requesters. Each requester asks for an interval of len+1 clock cycles. The
// winner owns the counter while it runs from 0 up to the length that was
// latched at grant time. The owner then gets a one-cycle done pulse, and one
// turnaround cycle follows before the next grant can be issued.
//
// This block is the only one that loads, clears or advances the counter.
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   WIDTH  counter and length width in bits
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset (0 = reset)
//   req    per-requester request level, held high until done or abort
//   len    packed lengths, slice i = len[i*WIDTH +: WIDTH], sampled at grant
//   grant  one-hot owner of the counter, all-zero when the counter is free
//   count  shared counter value
//   done   one-cycle completion pulse to the owner
//   busy   high while any grant is active
//
// Optional build macro:
//   COUNT_SCHED_FIXED_PRIO_EN  when defined, arbitration is fixed priority and
//                              the lowest set req index wins. The rotating
//                              pointer is removed. All timing is unchanged.
// -----------------------------------------------------------------------------
module count_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] len,
  output logic [N_REQ-1:0]       grant,
  output logic [WIDTH-1:0]       count,
  output logic [N_REQ-1:0]       done,
  output logic                   busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state_reg,  state_next;
  logic [N_REQ-1:0]   grant_reg,  grant_next;
  logic [N_REQ-1:0]   done_reg,   done_next;
  logic [WIDTH-1:0]   count_reg,  count_next;
  logic [WIDTH-1:0]   target_reg, target_next;
  logic [IW-1:0]      owner_reg,  owner_next;
  logic               busy_reg,   busy_next;

  // The search starts at this requester index.
  logic [IW-1:0]      search_base;
  // This is the index that follows the current owner. It becomes the next
  // search start.
  logic [IW-1:0]      owner_succ;

  // Arbitration result.
  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [IW:0]        idx_sum;

  // Per-requester length slices, unpacked so that the winner can index them.
  logic [WIDTH-1:0]   len_slice [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_len_slice
      assign len_slice[gi] = len[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign owner_succ = (owner_reg == IW'(N_REQ - 1)) ? '0 : owner_reg + IW'(1);

`ifdef COUNT_SCHED_FIXED_PRIO_EN
  // In fixed priority, the search always starts at requester 0.
  assign search_base = '0;
`else
  logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
  assign search_base = rr_ptr_reg;
`endif

  // Find the first set req bit at or above search_base, wrapping modulo N_REQ.
  // Offsets are scanned from the highest to the lowest, so the smallest
  // offset is the last one written and wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx_sum   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_sum = {1'b0, search_base} + (IW+1)'(k);
      if (idx_sum >= (IW+1)'(N_REQ)) begin
        idx_sum = idx_sum - (IW+1)'(N_REQ);
      end
      if (req[idx_sum[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx_sum[IW-1:0];
      end
    end
  end

  // Next-state logic and output logic.
  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    count_next  = count_reg;
    target_next = target_reg;
    owner_next  = owner_reg;
    busy_next   = busy_reg;
    done_next   = '0;
`ifndef COUNT_SCHED_FIXED_PRIO_EN
    rr_ptr_next = rr_ptr_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (win_found) begin
          grant_next  = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          busy_next   = 1'b1;
          count_next  = '0;
          target_next = len_slice[win_idx];
          owner_next  = win_idx;
          state_next  = RUN;
        end
      end

      RUN: begin
        // An abort takes precedence over completion. The interval is
        // abandoned silently, with no done pulse.
        if (!req[owner_reg] || (count_reg == target_reg)) begin
          if (req[owner_reg]) begin
            done_next = grant_reg;
          end
          grant_next  = '0;
          busy_next   = 1'b0;
          count_next  = '0;
`ifndef COUNT_SCHED_FIXED_PRIO_EN
          rr_ptr_next = owner_succ;
`endif
          state_next  = RELEASE;
        end else begin
          // The count never exceeds the target, so it cannot wrap.
          count_next = count_reg + WIDTH'(1);
        end
      end

      RELEASE: begin
        // This is the turnaround cycle. No grant is issued here.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
        busy_next  = 1'b0;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      done_reg   <= '0;
      count_reg  <= '0;
      target_reg <= '0;
      owner_reg  <= '0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      done_reg   <= done_next;
      count_reg  <= count_next;
      target_reg <= target_next;
      owner_reg  <= owner_next;
      busy_reg   <= busy_next;
    end
  end

`ifndef COUNT_SCHED_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end
`endif

  assign grant = grant_reg;
  assign count = count_reg;
  assign done  = done_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_count_sched.sv
// -----------------------------------------------------------------------------
// tb_count_sched
//
// This is a self-checking bench for count_sched. A transaction-level model
// tracks the current owner, the grant cycles left and the turnaround gap.
// The model compares the grant, count, done and busy outputs on every cycle.
// Directed scenarios come first, followed by randomized request traffic.
// -----------------------------------------------------------------------------
module tb_count_sched;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   len;
  logic [N-1:0]     grant;
  logic [W-1:0]     count;
  logic [N-1:0]     done;
  logic             busy;

  count_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .grant (grant),
    .count (count),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_total = 0;
  int chk_pass  = 0;

  // Reference model state.
  int m_owner;      // -1 when free
  int m_tgt;        // length latched at grant
  int m_left;       // grant cycles still to run, including the current one
  int m_gap;        // turnaround cycles still to wait before a grant
  int m_ptr;        // search start for the next grant
  int m_elapsed;    // cycles the current owner has held the counter
  logic [N-1:0] e_done;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_total++;
    if (got === exp) chk_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    m_owner   = -1;
    m_tgt     = 0;
    m_left    = 0;
    m_gap     = 0;
    m_ptr     = 0;
    m_elapsed = 0;
    e_done    = '0;
  endfunction

  // Apply one rising clock edge to the model, using the inputs seen at that edge.
  function automatic void model_edge();
    int best;
    if (!rst) begin
      model_reset();
      return;
    end
    e_done = '0;
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        $display("txn: requester %0d aborted after %0d cycles (len %0d)", m_owner, m_elapsed, m_tgt);
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = 1;
      end else begin
        m_left--;
        m_elapsed++;
        if (m_left == 0) begin
          $display("txn: requester %0d done after %0d cycles (len %0d)", m_owner, m_elapsed, m_tgt);
          e_done[m_owner] = 1'b1;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_gap   = 1;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (req != '0) begin
      best = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (req[i] && best < 0) best = i;
      end
      m_owner   = best;
      m_tgt     = int'(len[best*W +: W]);
      m_left    = m_tgt + 1;
      m_elapsed = 0;
    end
`ifdef COUNT_SCHED_FIXED_PRIO_EN
    m_ptr = 0;
`endif
  endfunction

  task automatic compare_outputs();
    logic [31:0] eg, ec;
    eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    ec = (m_owner >= 0) ? 32'(m_tgt + 1 - m_left) : 32'd0;
    check_val("grant", 32'(grant), eg);
    check_val("count", 32'(count), ec);
    check_val("done",  32'(done),  32'(e_done));
    check_val("busy",  32'(busy),  (m_owner >= 0) ? 32'd1 : 32'd0);
  endtask

  // Advance one edge. The model is updated at the edge and the outputs are
  // checked on the falling edge. The caller drives inputs after this returns.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ticks(2);
    rst = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    int order_q[$];
    int exp_order [5];
    logic [N-1:0] prev_grant;

    rst = 1'b0;
    req = '0;
    len = '0;
    model_reset();
    @(negedge clk);
    compare_outputs();
    ticks(2);
    rst = 1'b1;
    ticks(2);

    // Single request with len0=3.
    len[0*W +: W] = 8'd3;
    req = 4'b0001;
    ticks(5);
    req = 4'b0000;
    ticks(3);

    // Fairness: all requesters held, all lengths 1.
    do_reset();
    for (int i = 0; i < N; i++) len[i*W +: W] = 8'd1;
    req = 4'b1111;
    prev_grant = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (prev_grant == '0 && grant != '0) order_q.push_back(onehot_idx(grant));
      prev_grant = grant;
    end
`ifdef COUNT_SCHED_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    check_val("order_len", 32'(order_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check_val("order", (i < order_q.size()) ? 32'(order_q[i]) : 32'hffff_ffff, 32'(exp_order[i]));
    end
    req = '0;
    ticks(4);

    // Boundaries: len0=0, then len0=255.
    do_reset();
    len[0*W +: W] = 8'd0;
    req = 4'b0001;
    ticks(2);
    req = '0;
    ticks(3);
    len[0*W +: W] = 8'd255;
    req = 4'b0001;
    ticks(257);
    req = '0;
    ticks(3);

    // Abort: requester 1 drops when count reaches 4, and requester 2 is pending.
    len[1*W +: W] = 8'd10;
    len[2*W +: W] = 8'd2;
    req = 4'b0010;
    ticks(5);
    check_val("abort_cnt4", 32'(count), 32'd4);
    req = 4'b0100;
    ticks(3);
    check_val("abort_next", 32'(grant), 32'b0100);
    ticks(3);
    req = '0;
    ticks(3);

    // Asynchronous reset while the counter is at 5.
    len[0*W +: W] = 8'd10;
    req = 4'b0001;
    ticks(6);
    check_val("pre_rst_cnt", 32'(count), 32'd5);
    #2 rst = 1'b0;
    #1 model_reset();
    compare_outputs();
    ticks(2);
    rst = 1'b1;
    tick();
    check_val("post_rst_grant", 32'(grant), 32'b0001);
    req = '0;
    ticks(3);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            req[i] = 1'b1;
            len[i*W +: W] = 8'($urandom_range(15));
          end
        end else begin
          if (e_done[i] && $urandom_range(1) == 0) req[i] = 1'b0;
          else if (m_owner == i && $urandom_range(39) == 0) req[i] = 1'b0;
          // Length changes after the grant must be ignored.
          if ($urandom_range(7) == 0) len[i*W +: W] = 8'($urandom);
        end
      end
      tick();
    end
    req = '0;
    ticks(4);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
